// File: rtl/udp_app_stats_batch_reader.sv
// UDP app stats batch reader: serves NoC stats read requests with a
// summary flit followed by up to MAX_BATCH consecutive log entries.
module udp_app_stats_batch_reader #(
   parameter int SRC_X          = -1,
   parameter int SRC_Y          = -1,
   parameter int UDP_TX_X       = 0,
   parameter int UDP_TX_Y       = 0,
   parameter int NUM_CHAN       = 4,
   parameter int DEPTH_LOG2     = 8,
   parameter int ENTRY_W        = 128,
   parameter int MAX_BATCH      = 16,
   parameter int NOC_DATA_WIDTH = 256,
   localparam int CHAN_W = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1,
   localparam int CNT_W  = $clog2(MAX_BATCH + 1)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           noc_in_val,
   input  logic [NOC_DATA_WIDTH-1:0]      noc_in_data,
   output logic                           noc_in_rdy,
   output logic                           noc_out_val,
   output logic [NOC_DATA_WIDTH-1:0]      noc_out_data,
   input  logic                           noc_out_rdy,
   output logic                           log_rd_req_val,
   output logic [CHAN_W-1:0]              log_rd_req_chan,
   output logic [DEPTH_LOG2-1:0]          log_rd_req_addr,
   input  logic [ENTRY_W-1:0]             log_rd_resp_data,
   input  logic [NUM_CHAN*DEPTH_LOG2-1:0] curr_wr_addr,
   input  logic [NUM_CHAN-1:0]            has_wrapped
);

   localparam int W     = NOC_DATA_WIDTH;
   localparam int D     = DEPTH_LOG2;
   localparam int SUM_W = CHAN_W + 2 * D + CNT_W + 2;
   localparam logic [7:0] UDP_TX_SEGMENT = 8'd2;

   typedef enum logic [3:0] {
      IDLE, RX_META, RX_REQ, DRAIN, CALC,
      TX_HDR, TX_META, TX_SUM, RD_ISSUE, RD_WAIT, TX_DATA
   } state_t;

   state_t              state_q, state_d;
   logic [7:0]          hdr_len_q, rx_cnt_q;
   logic [95:0]         meta_q;
   logic [CHAN_W-1:0]   chan_q;
   logic [D-1:0]        start_q, ptr_q;
   logic [CNT_W-1:0]    count_q, n_q, idx_q;
   logic                err_q, wrapped_q;
   logic [ENTRY_W-1:0]  entry_q;

   logic                in_hs, out_hs;
   logic [D-1:0]        sel_ptr;
   logic                sel_wrapped, sel_err;
   logic [31:0]         avail, lim;
   logic [CNT_W-1:0]    n_calc;
   logic [15:0]         dlen;

   // Select channel pointer/flag and clamp the batch length.
   always_comb begin
      sel_ptr     = '0;
      sel_wrapped = 1'b0;
      sel_err     = (int'(chan_q) >= NUM_CHAN);
      for (int c = 0; c < NUM_CHAN; c++) begin
         if (int'(chan_q) == c) begin
            sel_ptr     = curr_wr_addr[c*D +: D];
            sel_wrapped = has_wrapped[c];
         end
      end
      avail = sel_wrapped ? (32'd1 << D)
                          : (32'(sel_ptr) - 32'(start_q));
      lim = 32'(count_q);
      if (lim > 32'(MAX_BATCH)) lim = 32'(MAX_BATCH);
      if (lim > avail) lim = avail;
      if (sel_err || (!sel_wrapped && start_q >= sel_ptr)) lim = '0;
      n_calc = CNT_W'(lim);
   end

   assign dlen   = 16'((32'(n_q) + 32'd1) * 32'(W / 8));
   assign in_hs  = noc_in_val & noc_in_rdy;
   assign out_hs = noc_out_val & noc_out_rdy;

   // Next state, handshake strobes and response flit formatting.
   always_comb begin
      state_d         = state_q;
      noc_in_rdy      = 1'b0;
      noc_out_val     = 1'b0;
      noc_out_data    = '0;
      log_rd_req_val  = 1'b0;
      log_rd_req_chan = chan_q;
      log_rd_req_addr = start_q + D'(idx_q);
      unique case (state_q)
         IDLE: begin
            noc_in_rdy = 1'b1;
            if (noc_in_val) state_d = RX_META;
         end
         RX_META: begin
            noc_in_rdy = 1'b1;
            if (noc_in_val) state_d = RX_REQ;
         end
         RX_REQ: begin
            noc_in_rdy = 1'b1;
            if (noc_in_val) state_d = (hdr_len_q > 8'd2) ? DRAIN : CALC;
         end
         DRAIN: begin
            noc_in_rdy = 1'b1;
            if (noc_in_val && (rx_cnt_q + 8'd1 >= hdr_len_q)) state_d = CALC;
         end
         CALC: state_d = TX_HDR;
         TX_HDR: begin
            noc_out_val = 1'b1;
            noc_out_data[W-1 -: 56] = {8'(UDP_TX_X), 8'(UDP_TX_Y),
                                       8'(SRC_X), 8'(SRC_Y),
                                       8'(32'(n_q) + 32'd2),
                                       UDP_TX_SEGMENT, 8'd1};
            if (noc_out_rdy) state_d = TX_META;
         end
         TX_META: begin
            noc_out_val = 1'b1;
            noc_out_data[W-1 -: 112] = {meta_q[63:32], meta_q[95:64],
                                        meta_q[15:0], meta_q[31:16], dlen};
            if (noc_out_rdy) state_d = TX_SUM;
         end
         TX_SUM: begin
            noc_out_val = 1'b1;
            noc_out_data[W-1 -: SUM_W] = {chan_q, start_q, n_q,
                                          err_q, wrapped_q, ptr_q};
            if (noc_out_rdy) state_d = (n_q != '0) ? RD_ISSUE : IDLE;
         end
         RD_ISSUE: begin
            log_rd_req_val = 1'b1;
            state_d = RD_WAIT;
         end
         RD_WAIT: state_d = TX_DATA;
         TX_DATA: begin
            noc_out_val = 1'b1;
            noc_out_data[W-1 -: ENTRY_W] = entry_q;
            if (noc_out_rdy) state_d = (idx_q + 1'b1 == n_q) ? IDLE : RD_ISSUE;
         end
         default: state_d = IDLE;
      endcase
      if (!rst_n) begin
         noc_in_rdy     = 1'b0;
         noc_out_val    = 1'b0;
         log_rd_req_val = 1'b0;
      end
   end

   // State register plus request capture, snapshot and entry buffer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         hdr_len_q <= '0;
         rx_cnt_q  <= '0;
         meta_q    <= '0;
         chan_q    <= '0;
         start_q   <= '0;
         count_q   <= '0;
         ptr_q     <= '0;
         n_q       <= '0;
         idx_q     <= '0;
         err_q     <= 1'b0;
         wrapped_q <= 1'b0;
         entry_q   <= '0;
      end else begin
         state_q <= state_d;
         unique case (state_q)
            IDLE: if (in_hs) begin
               hdr_len_q <= noc_in_data[W-33 -: 8];
               rx_cnt_q  <= '0;
               idx_q     <= '0;
            end
            RX_META: if (in_hs) begin
               meta_q   <= noc_in_data[W-1 -: 96];
               rx_cnt_q <= rx_cnt_q + 8'd1;
            end
            RX_REQ: if (in_hs) begin
               chan_q   <= noc_in_data[W-1 -: CHAN_W];
               start_q  <= noc_in_data[W-1-CHAN_W -: D];
               count_q  <= noc_in_data[W-1-CHAN_W-D -: CNT_W];
               rx_cnt_q <= rx_cnt_q + 8'd1;
            end
            DRAIN: if (in_hs) rx_cnt_q <= rx_cnt_q + 8'd1;
            CALC: begin
               err_q     <= sel_err;
               wrapped_q <= sel_wrapped;
               ptr_q     <= sel_ptr;
               n_q       <= n_calc;
            end
            RD_WAIT: entry_q <= log_rd_resp_data;
            TX_DATA: if (out_hs) idx_q <= idx_q + 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_udp_app_stats_batch_reader.sv
// Directed scoreboard bench for udp_app_stats_batch_reader
// with a one-cycle-latency log model and random downstream backpressure.
module tb_udp_app_stats_batch_reader;

   localparam int W  = 256;
   localparam int NC = 3;
   localparam int CW = 2;
   localparam int D  = 8;

   logic            clk, rst_n;
   logic            noc_in_val, noc_in_rdy;
   logic [W-1:0]    noc_in_data;
   logic            noc_out_val, noc_out_rdy;
   logic [W-1:0]    noc_out_data;
   logic            log_rd_req_val;
   logic [CW-1:0]   log_rd_req_chan;
   logic [D-1:0]    log_rd_req_addr;
   logic [127:0]    log_rd_resp_data;
   logic [NC*D-1:0] curr_wr_addr;
   logic [NC-1:0]   has_wrapped;

   int checks = 0;
   int errors = 0;
   int rdy_mode = 0;
   logic [W-1:0] exp_q[$];
   logic [9:0]   addr_q[$];

   udp_app_stats_batch_reader #(
      .SRC_X(1), .SRC_Y(-1), .UDP_TX_X(2), .UDP_TX_Y(3),
      .NUM_CHAN(NC), .DEPTH_LOG2(D), .ENTRY_W(128),
      .MAX_BATCH(16), .NOC_DATA_WIDTH(W)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .noc_in_val(noc_in_val), .noc_in_data(noc_in_data),
      .noc_in_rdy(noc_in_rdy),
      .noc_out_val(noc_out_val), .noc_out_data(noc_out_data),
      .noc_out_rdy(noc_out_rdy),
      .log_rd_req_val(log_rd_req_val), .log_rd_req_chan(log_rd_req_chan),
      .log_rd_req_addr(log_rd_req_addr), .log_rd_resp_data(log_rd_resp_data),
      .curr_wr_addr(curr_wr_addr), .has_wrapped(has_wrapped)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [W-1:0] got,
                      input logic [W-1:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s: got %h want %h", tag, got, want);
      end
   endtask

   function automatic logic [127:0] log_entry(input logic [1:0] ch,
                                               input logic [7:0] a);
      return {6'd0, ch, a, 16'hBEEF, 24'hC0FFEE, a ^ 8'h5A,
              32'h1234_0000 | {24'd0, a}, 16'(ch) * 16'd77, 16'hD00D};
   endfunction

   // downstream ready: 0 always, 1 random, 2 held low
   initial begin
      noc_out_rdy = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (rdy_mode == 0) noc_out_rdy = 1'b1;
         else if (rdy_mode == 1) noc_out_rdy = 1'($urandom_range(0, 1));
         else noc_out_rdy = 1'b0;
      end
   end

   // log memory: data valid in the cycle after the strobe, junk otherwise
   initial begin
      logic pend;
      logic [1:0] pch;
      logic [7:0] pad;
      log_rd_resp_data = '0;
      forever begin
         @(negedge clk);
         pend = rst_n && log_rd_req_val;
         pch = log_rd_req_chan;
         pad = log_rd_req_addr;
         @(posedge clk); #1;
         if (pend) log_rd_resp_data = log_entry(pch, pad);
         else log_rd_resp_data = {$urandom, $urandom, $urandom, $urandom};
      end
   end

   // output monitor: scoreboard pops, stall stability, read strobes
   initial begin
      logic prev_stall;
      logic [W-1:0] prev_data;
      prev_stall = 1'b0;
      prev_data = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               chk("stable_val", W'(noc_out_val), W'(1));
               chk("stable_data", noc_out_data, prev_data);
            end
            if (log_rd_req_val) begin
               chk("rd_while_out", W'(noc_out_val), W'(0));
               if (addr_q.size() == 0) chk("rd_extra", W'(1), W'(0));
               else chk("rd_addr", W'({log_rd_req_chan, log_rd_req_addr}),
                        W'(addr_q.pop_front()));
            end
            if (noc_out_val && noc_out_rdy) begin
               if (exp_q.size() == 0) chk("out_extra", noc_out_data, '0);
               else chk("out_flit", noc_out_data, exp_q.pop_front());
            end
            prev_stall = noc_out_val && !noc_out_rdy;
            prev_data = noc_out_data;
         end
      end
   end

   task automatic send_flit(input logic [W-1:0] d);
      bit ok;
      ok = 1'b0;
      @(posedge clk); #1;
      noc_in_val = 1'b1;
      noc_in_data = d;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (noc_in_rdy) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("in_timeout", W'(0), W'(1));
      @(posedge clk); #1;
      noc_in_val = 1'b0;
   endtask

   task automatic wait_done();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && addr_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("resp_timeout", W'(0), W'(1));
      @(negedge clk);
      chk("idle_rdy", W'(noc_in_rdy), W'(1));
      chk("idle_val", W'(noc_out_val), W'(0));
   endtask

   task automatic do_req(input int chan, input int start, input int count,
                         input int extra, input bit snap, input bit wait_it);
      int ptr, lim, n;
      bit wr, err;
      logic [W-1:0] f;
      logic [31:0] sip, dip;
      logic [15:0] sp, dp;
      logic [7:0] old_ptr;
      err = (chan >= NC);
      ptr = err ? 0 : int'(curr_wr_addr[chan*D +: D]);
      wr = err ? 1'b0 : has_wrapped[chan];
      lim = wr ? 256 : ptr - start;
      if (lim < 0) lim = 0;
      n = (count > 16) ? 16 : count;
      if (n > lim) n = lim;
      if (err) n = 0;
      sip = $urandom; dip = $urandom;
      sp = 16'($urandom); dp = 16'($urandom);
      f = '0;
      f[W-1 -: 56] = {8'd2, 8'd3, 8'd1, 8'hFF, 8'(2 + n), 8'd2, 8'd1};
      exp_q.push_back(f);
      f = '0;
      f[W-1 -: 112] = {dip, sip, dp, sp, 16'((1 + n) * 32)};
      exp_q.push_back(f);
      f = '0;
      f[W-1 -: 25] = {2'(chan), 8'(start), 5'(n), err, wr, 8'(ptr)};
      exp_q.push_back(f);
      for (int i = 0; i < n; i++) begin
         f = '0;
         f[W-1 -: 128] = log_entry(2'(chan), 8'(start + i));
         exp_q.push_back(f);
         addr_q.push_back({2'(chan), 8'(start + i)});
      end
      f = '0;
      f[W-1 -: 56] = {32'h0506_0708, 8'(2 + extra), 8'd1, 8'd1};
      send_flit(f);
      f = '0;
      f[W-1 -: 96] = {sip, dip, sp, dp};
      send_flit(f);
      f = '0;
      f[W-1 -: 15] = {2'(chan), 8'(start), 5'(count)};
      send_flit(f);
      for (int i = 0; i < extra; i++) send_flit({8{$urandom}});
      old_ptr = curr_wr_addr[chan*D +: D];
      if (snap) begin
         repeat (3) @(posedge clk);
         #1;
         curr_wr_addr[chan*D +: D] = 8'd2;
         has_wrapped[chan] = 1'b1;
      end
      if (wait_it) wait_done();
      if (snap) begin
         curr_wr_addr[chan*D +: D] = old_ptr;
         has_wrapped[chan] = wr;
      end
   endtask

   initial begin
      bit ok;
      rst_n = 1'b0;
      noc_in_val = 1'b0;
      noc_in_data = '0;
      curr_wr_addr = {8'd3, 8'd10, 8'd7};
      has_wrapped = 3'b001;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_rdy", W'(noc_in_rdy), W'(0));
      chk("rst_out_val", W'(noc_out_val), W'(0));
      chk("rst_rd_val", W'(log_rd_req_val), W'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;

      do_req(1, 2, 4, 0, 0, 1);
      do_req(0, 254, 5, 0, 0, 1);
      do_req(2, 1, 16, 0, 0, 1);
      do_req(2, 3, 16, 0, 0, 1);
      do_req(0, 10, 31, 0, 0, 1);
      do_req(3, 0, 4, 0, 0, 1);
      rdy_mode = 1;
      do_req(1, 0, 9, 0, 1, 1);
      do_req(0, 100, 12, 0, 0, 1);
      rdy_mode = 0;
      do_req(1, 5, 3, 2, 0, 1);
      do_req(2, 0, 3, 0, 0, 1);

      rdy_mode = 1;
      do_req(1, 0, 4, 0, 0, 0);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (exp_q.size() <= 2) begin
            ok = 1'b1;
            break;
         end
      end
      rdy_mode = 2;
      for (int i = 0; i < 200 && ok; i++) begin
         @(negedge clk);
         if (noc_out_val && !noc_out_rdy) break;
      end
      chk("stall_reached", W'(ok && noc_out_val && !noc_out_rdy), W'(1));
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_out_val", W'(noc_out_val), W'(0));
      chk("mid_rst_in_rdy", W'(noc_in_rdy), W'(0));
      chk("mid_rst_rd_val", W'(log_rd_req_val), W'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_q.delete();
      addr_q.delete();
      rdy_mode = 0;
      @(negedge clk);
      chk("post_rst_in_rdy", W'(noc_in_rdy), W'(1));
      chk("post_rst_out_val", W'(noc_out_val), W'(0));
      do_req(1, 2, 4, 0, 0, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
